instr_encode_loader: RTL and testbench

// - Inverse of the decode stage: packs field-level instruction requests (cond/op/funct/Rn/Rd/src2 or imm24)

---
 rtl/instr_encode_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encode_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode_loader
// Brief    : Packs field-level instruction requests into 32-bit ARM-subset
//            words and writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encode_loader #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 DEPTH     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_cond_i,
  input  logic [1:0]        req_op_i,
  input  logic [5:0]        req_funct_i,
  input  logic [3:0]        req_rn_i,
  input  logic [3:0]        req_rd_i,
  input  logic [11:0]       req_src2_i,
  input  logic [23:0]       req_imm24_i,
  input  logic              req_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        words_written_o
);

  localparam logic [7:0]        C_DEPTH = 8'(DEPTH);
  localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          count_q, count_d;
  logic                last_q, last_d;

  logic [31:0]         w_enc;
  logic                w_illegal;
  logic                w_dp_bad;

  // Branch words force the L bit to zero; funct is ignored for BR.
  always_comb begin
    if (req_op_i == 2'b10) begin
      w_enc = {req_cond_i, 2'b10, 2'b10, req_imm24_i};
    end else begin
      w_enc = {req_cond_i, req_op_i, req_funct_i, req_rn_i, req_rd_i, req_src2_i};
    end
  end

  // DP encodings the decode stage cannot execute: reserved opcodes and
  // compare-class ops without the S bit.
  always_comb begin
    w_dp_bad = 1'b0;
    case (req_funct_i[4:1])
      4'b0101, 4'b0110, 4'b0111, 4'b1111: w_dp_bad = 1'b1;
      default:                            w_dp_bad = 1'b0;
    endcase
    if ((req_funct_i[4:3] == 2'b10) && !req_funct_i[0]) begin
      w_dp_bad = 1'b1;
    end
  end

  assign w_illegal = (req_op_i == 2'b11)
                   || ((req_op_i == 2'b00) && w_dp_bad)
                   || (count_q == C_DEPTH);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LOAD;
          addr_d  = BASE_ADDR;
          count_d = 8'd0;
        end
      end
      S_LOAD: begin
        if (req_valid_i) begin
          if (w_illegal) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WRITE;
            wdata_d = w_enc;
            last_d  = req_last_i;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + C_STEP;
        count_d = count_q + 8'd1;
        state_d = last_q ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      count_q <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign req_ready_o     = (state_q == S_LOAD);
  assign imem_we_o       = (state_q == S_WRITE);
  assign busy_o          = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done_o          = (state_q == S_DONE);
  assign err_o           = (state_q == S_ERR);
  assign imem_addr_o     = addr_q;
  assign imem_wdata_o    = wdata_q;
  assign words_written_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encode_loader
// Brief    : Directed vector bench for instr_encode_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

  typedef struct {
    string       name;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_cond = '0;
  logic [1:0]  req_op = '0;
  logic [5:0]  req_funct = '0;
  logic [3:0]  req_rn = '0;
  logic [3:0]  req_rd = '0;
  logic [11:0] req_src2 = '0;
  logic [23:0] req_imm24 = '0;
  logic        req_last = 1'b0;

  logic        req_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0]  words_written;
  logic        req_ready2, imem_we2, busy2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [7:0]  words_written2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'd0), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start_i(start), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_cond_i(req_cond), .req_op_i(req_op),
    .req_funct_i(req_funct), .req_rn_i(req_rn), .req_rd_i(req_rd),
    .req_src2_i(req_src2), .req_imm24_i(req_imm24), .req_last_i(req_last),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .words_written_o(words_written)
  );

  // Shares all stimulus with dut; only the overflow sequence is checked here.
  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'd0), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start_i(start), .req_valid_i(req_valid),
    .req_ready_o(req_ready2), .req_cond_i(req_cond), .req_op_i(req_op),
    .req_funct_i(req_funct), .req_rn_i(req_rn), .req_rd_i(req_rd),
    .req_src2_i(req_src2), .req_imm24_i(req_imm24), .req_last_i(req_last),
    .imem_we_o(imem_we2), .imem_addr_o(imem_addr2), .imem_wdata_o(imem_wdata2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .words_written_o(words_written2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v, input logic last);
    req_cond  = v.cond;
    req_op    = v.op;
    req_funct = v.funct;
    req_rn    = v.rn;
    req_rd    = v.rd;
    req_src2  = v.src2;
    req_imm24 = v.imm24;
    req_last  = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns just after the handshake edge.
  task automatic send(input vec_t v, input logic last);
    int n;
    set_fields(v, last);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout %s: got ready=0 want ready=1", v.name);
    end
    tick();
    req_valid = 1'b0;
  endtask

  vec_t vecs[12];
  vec_t bb[3];
  logic rdy_exp[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, wcnt, w2, samp;
    logic prev_we;

    vecs[0]  = '{"add_imm",   4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0,      1'b1, 32'hE2812005};
    vecs[1]  = '{"cmp_s",     4'hE, 2'b00, 6'b110101, 4'h1, 4'h0, 12'h000, 24'h0,      1'b1, 32'hE3510000};
    vecs[2]  = '{"cmp_no_s",  4'hE, 2'b00, 6'b110100, 4'h1, 4'h0, 12'h000, 24'h0,      1'b0, 32'h0};
    vecs[3]  = '{"ldr",       4'hE, 2'b01, 6'b011001, 4'h0, 4'h3, 12'h008, 24'h0,      1'b1, 32'hE5903008};
    vecs[4]  = '{"br_back",   4'hE, 2'b10, 6'b000000, 4'h0, 4'h0, 12'h000, 24'hFFFFFE, 1'b1, 32'hEAFFFFFE};
    vecs[5]  = '{"br_funct",  4'h0, 2'b10, 6'b111111, 4'hF, 4'hF, 12'hFFF, 24'h123456, 1'b1, 32'h0A123456};
    vecs[6]  = '{"op11",      4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 12'h000, 24'h0,      1'b0, 32'h0};
    vecs[7]  = '{"dp_0101",   4'hE, 2'b00, 6'b001010, 4'h0, 4'h0, 12'h000, 24'h0,      1'b0, 32'h0};
    vecs[8]  = '{"dp_0110",   4'hE, 2'b00, 6'b001100, 4'h0, 4'h0, 12'h000, 24'h0,      1'b0, 32'h0};
    vecs[9]  = '{"dp_1111",   4'hE, 2'b00, 6'b011110, 4'h0, 4'h0, 12'h000, 24'h0,      1'b0, 32'h0};
    vecs[10] = '{"tst_s",     4'h0, 2'b00, 6'b010001, 4'h3, 4'h0, 12'h0FF, 24'h0,      1'b1, 32'h011300FF};
    vecs[11] = '{"mem_0101",  4'hE, 2'b01, 6'b001010, 4'h2, 4'h4, 12'h123, 24'h0,      1'b1, 32'hE4A24123};

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_we",    {31'd0, imem_we},   32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_err",   {31'd0, err},       32'd0);
    chk("rst_addr",  imem_addr,          32'd0);
    chk("rst_wdata", imem_wdata,         32'd0);
    chk("rst_words", {24'd0, words_written}, 32'd0);

    // Single-word programs.
    for (int i = 0; i < 12; i++) begin
      do_start();
      chk({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
      send(vecs[i], 1'b1);
      if (vecs[i].legal) begin
        chk({vecs[i].name, "_we"},    {31'd0, imem_we}, 32'd1);
        chk({vecs[i].name, "_addr"},  imem_addr,        32'd0);
        chk({vecs[i].name, "_wdata"}, imem_wdata,       vecs[i].word);
        tick();
        chk({vecs[i].name, "_we_off"}, {31'd0, imem_we}, 32'd0);
        chk({vecs[i].name, "_done"},   {31'd0, done},    32'd1);
        chk({vecs[i].name, "_err"},    {31'd0, err},     32'd0);
        chk({vecs[i].name, "_words"},  {24'd0, words_written}, 32'd1);
        chk({vecs[i].name, "_addr4"},  imem_addr,        32'd4);
      end else begin
        chk({vecs[i].name, "_we"},    {31'd0, imem_we}, 32'd0);
        chk({vecs[i].name, "_err"},   {31'd0, err},     32'd1);
        chk({vecs[i].name, "_done"},  {31'd0, done},    32'd0);
        chk({vecs[i].name, "_busy"},  {31'd0, busy},    32'd0);
        chk({vecs[i].name, "_words"}, {24'd0, words_written}, 32'd0);
        tick();
        chk({vecs[i].name, "_err_sticky"}, {31'd0, err},     32'd1);
        chk({vecs[i].name, "_we_off"},     {31'd0, imem_we}, 32'd0);
      end
    end

    // Back-to-back, valid held high; dut2 (DEPTH=2) overflows on word 3.
    bb[0] = vecs[0];
    bb[1] = vecs[3];
    bb[2] = vecs[4];
    rdy_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start();
    hs = 0; wcnt = 0; w2 = 0; samp = 0; prev_we = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (samp < 5) begin
        chk($sformatf("bb_ready_%0d", samp), {31'd0, req_ready}, {31'd0, rdy_exp[samp]});
        samp++;
      end
      if (imem_we) begin
        chk("bb_we_gap", {31'd0, prev_we}, 32'd0);
        chk($sformatf("bb_addr_%0d", wcnt), imem_addr, 32'(wcnt * 4));
        chk($sformatf("bb_wdata_%0d", wcnt), imem_wdata, bb[wcnt % 3].word);
        wcnt++;
      end
      if (imem_we2) begin
        chk($sformatf("ovf_addr_%0d", w2), imem_addr2, 32'(w2 * 4));
        w2++;
      end
      prev_we = imem_we;
      if (req_ready && hs < 3) begin
        set_fields(bb[hs], hs == 2);
        hs++;
      end else if (hs == 3 && !req_ready) begin
        req_valid = 1'b0;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("bb_writes", 32'(wcnt), 32'd3);
    chk("bb_done",   {31'd0, done}, 32'd1);
    chk("bb_words",  {24'd0, words_written}, 32'd3);
    chk("bb_addr_end", imem_addr, 32'd12);
    chk("ovf_writes", 32'(w2), 32'd2);
    chk("ovf_err",   {31'd0, err2},  32'd1);
    chk("ovf_done",  {31'd0, done2}, 32'd0);
    chk("ovf_words", {24'd0, words_written2}, 32'd2);

    // start ignored mid-load, then reset during the second write.
    do_start();
    send(vecs[0], 1'b0);
    chk("mid_we1", {31'd0, imem_we}, 32'd1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_still_load", {31'd0, req_ready}, 32'd1);
    chk("mid_words", {24'd0, words_written}, 32'd1);
    send(vecs[3], 1'b1);
    chk("mid_we2",   {31'd0, imem_we}, 32'd1);
    chk("mid_addr2", imem_addr, 32'd4);
    reset = 1'b1;
    tick();
    chk("rw_we",    {31'd0, imem_we},   32'd0);
    chk("rw_ready", {31'd0, req_ready}, 32'd0);
    chk("rw_busy",  {31'd0, busy},      32'd0);
    chk("rw_done",  {31'd0, done},      32'd0);
    chk("rw_err",   {31'd0, err},       32'd0);
    chk("rw_addr",  imem_addr,          32'd0);
    chk("rw_wdata", imem_wdata,         32'd0);
    chk("rw_words", {24'd0, words_written}, 32'd0);
    reset = 1'b0;
    do_start();
    send(vecs[4], 1'b1);
    chk("post_we",    {31'd0, imem_we}, 32'd1);
    chk("post_addr",  imem_addr,        32'd0);
    chk("post_wdata", imem_wdata,       32'hEAFFFFFE);
    tick();
    tick();
    tick();
    chk("post_done_sticky", {31'd0, done}, 32'd1);
    chk("post_words", {24'd0, words_written}, 32'd1);
    chk("post_wdata_hold", imem_wdata, 32'hEAFFFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
